// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared pipeline definitions: forwarding select encodings, register-address geometry
// and the per-stage record carried by the EX/DM/WB stage registers and RB_Block.
package fwd_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_DM  = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rw;
    logic                  wr_en;
    logic                  is_load;
  } stage_rec_t;

  // A stage can supply an operand only if it really writes that (non-zero) register.
  function automatic logic stage_hit(input stage_rec_t            rec,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic                  use_src,
                                     input logic [REG_ADDR_W-1:0] zero_reg);
    return rec.valid & rec.wr_en & (rec.rw == src) & (src != zero_reg) & use_src;
  endfunction

endpackage

// File: rtl/fwd_sel_prio.sv
// Per-operand forwarding select, youngest producer first; purely combinational,
// no flow control. Also flags an EX-stage load producer for load-use stall detection.
module fwd_sel_prio #(
  parameter int                    REG_ADDR_W = fwd_hazard_ctrl_pkg::REG_ADDR_W,
  parameter logic [REG_ADDR_W-1:0] ZERO_REG   = fwd_hazard_ctrl_pkg::ZERO_REG
) (
  input  logic                            id_valid,
  input  logic [REG_ADDR_W-1:0]           src,
  input  logic                            use_src,
  input  fwd_hazard_ctrl_pkg::stage_rec_t ex,
  input  fwd_hazard_ctrl_pkg::stage_rec_t dm,
  input  fwd_hazard_ctrl_pkg::stage_rec_t wb,
  output logic [1:0]                      sel,
  output logic                            ex_load_hit
);
  import fwd_hazard_ctrl_pkg::*;

  logic hit_ex, hit_dm, hit_wb;

  assign hit_ex = stage_hit(ex, src, use_src, ZERO_REG);
  assign hit_dm = stage_hit(dm, src, use_src, ZERO_REG);
  assign hit_wb = stage_hit(wb, src, use_src, ZERO_REG);

  assign ex_load_hit = hit_ex & ex.is_load;

  always_comb begin
    sel = FWD_REG;
    if (id_valid) begin
      if (hit_ex)      sel = FWD_EX;
      else if (hit_dm) sel = FWD_DM;
      else if (hit_wb) sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding selects, load-use stall and DM write address for the register-bank read stage.
// Outputs are combinational from decode inputs and EX/DM/WB records; stall holds PC and IF/ID.
module fwd_hazard_ctrl #(
  parameter int                    REG_ADDR_W = fwd_hazard_ctrl_pkg::REG_ADDR_W,
  parameter logic [REG_ADDR_W-1:0] ZERO_REG   = fwd_hazard_ctrl_pkg::ZERO_REG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_ra,
  input  logic [REG_ADDR_W-1:0] id_rb,
  input  logic                  id_use_a,
  input  logic                  id_use_b,
  input  logic [REG_ADDR_W-1:0] id_rw,
  input  logic                  id_wr_en,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic [1:0]            mux_sel_A,
  output logic [1:0]            mux_sel_B,
  output logic                  stall,
  output logic [REG_ADDR_W-1:0] RW_dm,
  output logic                  wr_en_dm
);
  import fwd_hazard_ctrl_pkg::*;

  stage_rec_t ex_q, dm_q, wb_q, new_rec;
  logic [1:0] sel_a, sel_b;
  logic       ld_hit_a, ld_hit_b, id_accept;

  fwd_sel_prio #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_sel_a (
    .id_valid    (id_valid),
    .src         (id_ra),
    .use_src     (id_use_a),
    .ex          (ex_q),
    .dm          (dm_q),
    .wb          (wb_q),
    .sel         (sel_a),
    .ex_load_hit (ld_hit_a)
  );

  fwd_sel_prio #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG(ZERO_REG)) u_sel_b (
    .id_valid    (id_valid),
    .src         (id_rb),
    .use_src     (id_use_b),
    .ex          (ex_q),
    .dm          (dm_q),
    .wb          (wb_q),
    .sel         (sel_b),
    .ex_load_hit (ld_hit_b)
  );

  // Flush wins over stall: a squashed instruction never waits on a load.
  assign stall     = ~rst & id_valid & ~flush & (ld_hit_a | ld_hit_b);
  assign id_accept = id_valid & ~stall & ~flush;

  always_comb begin
    new_rec = '0;
    if (id_accept) begin
      new_rec.valid   = 1'b1;
      new_rec.rw      = id_rw;
      new_rec.wr_en   = id_wr_en;
      new_rec.is_load = id_is_load;
    end
  end

  // Outputs read as idle while reset is held, independent of stale stage contents.
  assign mux_sel_A = rst ? FWD_REG : sel_a;
  assign mux_sel_B = rst ? FWD_REG : sel_b;
  assign RW_dm     = rst ? '0 : dm_q.rw;
  assign wr_en_dm  = ~rst & dm_q.valid & dm_q.wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
      dm_q <= '0;
      wb_q <= '0;
    end else begin
      wb_q <= dm_q;
      dm_q <= ex_q;
      ex_q <= new_rec;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: inputs change on the falling edge, outputs are
// checked 1ns later against hand-computed selects, stall and DM write-port values.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_a, id_use_b, id_wr_en, id_is_load, flush;
  logic [4:0] id_ra, id_rb, id_rw;
  logic [1:0] mux_sel_A, mux_sel_B;
  logic       stall, wr_en_dm;
  logic [4:0] RW_dm;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_ra      (id_ra),
    .id_rb      (id_rb),
    .id_use_a   (id_use_a),
    .id_use_b   (id_use_b),
    .id_rw      (id_rw),
    .id_wr_en   (id_wr_en),
    .id_is_load (id_is_load),
    .flush      (flush),
    .mux_sel_A  (mux_sel_A),
    .mux_sel_B  (mux_sel_B),
    .stall      (stall),
    .RW_dm      (RW_dm),
    .wr_en_dm   (wr_en_dm)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One decode cycle: drive after the falling edge, then settle before checking.
  task automatic cyc(input int v, input int ra, input int rb, input int ua, input int ub,
                     input int rw, input int we, input int ld, input int fl, input int rs);
    @(negedge clk);
    id_valid   = 1'(v);
    id_ra      = 5'(ra);
    id_rb      = 5'(rb);
    id_use_a   = 1'(ua);
    id_use_b   = 1'(ub);
    id_rw      = 5'(rw);
    id_wr_en   = 1'(we);
    id_is_load = 1'(ld);
    flush      = 1'(fl);
    rst        = 1'(rs);
    #1;
  endtask

  task automatic wr(input int rw);
    cyc(1, 1, 2, 1, 1, rw, 1, 0, 0, 0);
  endtask

  task automatic rd(input int ra, input int rb);
    cyc(1, ra, rb, 1, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic lw(input int rw);
    cyc(1, 1, 0, 1, 0, rw, 1, 1, 0, 0);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_ra = '0; id_rb = '0; id_use_a = 1'b0; id_use_b = 1'b0;
    id_rw = '0; id_wr_en = 1'b0; id_is_load = 1'b0; flush = 1'b0;

    // Reset held two cycles with a live decode instruction reading r3.
    cyc(1, 3, 0, 1, 0, 0, 0, 0, 0, 1);
    chk("rst0_selA", 32'(mux_sel_A), 0);
    chk("rst0_stall", 32'(stall), 0);
    chk("rst0_wr_en_dm", 32'(wr_en_dm), 0);
    chk("rst0_RW_dm", 32'(RW_dm), 0);
    cyc(1, 3, 3, 1, 1, 3, 1, 0, 0, 1);
    chk("rst1_selA", 32'(mux_sel_A), 0);
    chk("rst1_stall", 32'(stall), 0);
    rd(3, 0);
    chk("post_rst_selA", 32'(mux_sel_A), 0);
    chk("post_rst_wr_en_dm", 32'(wr_en_dm), 0);

    // Forwarding distance 1..4.
    wr(5);
    rd(5, 5);
    chk("ex_fwd_selA", 32'(mux_sel_A), 1);
    chk("ex_fwd_selB", 32'(mux_sel_B), 1);
    chk("ex_fwd_stall", 32'(stall), 0);
    wr(10); wr(11);
    rd(10, 10);
    chk("dm_fwd_selA", 32'(mux_sel_A), 2);
    chk("dm_fwd_selB", 32'(mux_sel_B), 2);
    wr(12); wr(13); wr(14);
    rd(12, 12);
    chk("wb_fwd_selA", 32'(mux_sel_A), 3);
    chk("wb_fwd_selB", 32'(mux_sel_B), 3);
    wr(15); wr(16); wr(17); wr(18);
    rd(15, 15);
    chk("bank_selA", 32'(mux_sel_A), 0);
    chk("bank_selB", 32'(mux_sel_B), 0);

    // Same register written in ex, dm and wb: youngest wins.
    wr(7); wr(7); wr(7);
    rd(7, 7);
    chk("prio_ex_selA", 32'(mux_sel_A), 1);
    chk("prio_ex_selB", 32'(mux_sel_B), 1);
    wr(7); wr(7); wr(19);
    rd(7, 7);
    chk("prio_dm_selA", 32'(mux_sel_A), 2);

    // Load-use: one stall cycle, bubble behind the load.
    lw(4);
    cyc(1, 4, 1, 1, 1, 8, 1, 0, 0, 0);
    chk("lu_stall", 32'(stall), 1);
    chk("lu_selA", 32'(mux_sel_A), 1);
    chk("lu_selB", 32'(mux_sel_B), 0);
    cyc(1, 4, 1, 1, 1, 8, 1, 0, 0, 0);
    chk("lu2_stall", 32'(stall), 0);
    chk("lu2_selA", 32'(mux_sel_A), 2);
    chk("lu2_selB", 32'(mux_sel_B), 0);
    chk("lu2_wr_en_dm", 32'(wr_en_dm), 1);
    chk("lu2_RW_dm", 32'(RW_dm), 4);
    cyc(0, 8, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("lu3_bubble_wr_en_dm", 32'(wr_en_dm), 0);
    chk("novalid_selA", 32'(mux_sel_A), 0);
    chk("lu3_stall", 32'(stall), 0);

    // Register zero and unused operand B.
    wr(0);
    rd(0, 0);
    chk("zero_selA", 32'(mux_sel_A), 0);
    chk("zero_selB", 32'(mux_sel_B), 0);
    wr(21);
    cyc(1, 1, 21, 1, 0, 9, 1, 0, 0, 0);
    chk("imm_selB", 32'(mux_sel_B), 0);

    // Flush in the cycle a load-use is detected.
    lw(22);
    cyc(1, 22, 2, 1, 1, 9, 1, 0, 1, 0);
    chk("flush_stall", 32'(stall), 0);
    idle();
    chk("flush1_wr_en_dm", 32'(wr_en_dm), 1);
    chk("flush1_RW_dm", 32'(RW_dm), 22);
    idle();
    chk("flush2_wr_en_dm", 32'(wr_en_dm), 0);

    // Reset (with a concurrent flush) while a load sits in dm.
    lw(23);
    wr(24);
    cyc(1, 24, 23, 1, 1, 0, 0, 0, 1, 1);
    chk("mrst_wr_en_dm", 32'(wr_en_dm), 0);
    chk("mrst_RW_dm", 32'(RW_dm), 0);
    chk("mrst_selA", 32'(mux_sel_A), 0);
    chk("mrst_stall", 32'(stall), 0);
    rd(24, 23);
    chk("mrst1_wr_en_dm", 32'(wr_en_dm), 0);
    chk("mrst1_RW_dm", 32'(RW_dm), 0);
    chk("mrst1_selA", 32'(mux_sel_A), 0);
    chk("mrst1_selB", 32'(mux_sel_B), 0);
    wr(25);
    rd(25, 25);
    chk("resume_selA", 32'(mux_sel_A), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
